// File: rtl/uart_watch_dog_if.sv
// Handshake bundle for uart_watch_dog: control/config inputs plus line-state outputs.
// Master drives the controls and preset; slave is the watchdog itself.
interface uart_watch_dog_if #(
  parameter int CNT_W = 32
);
  logic             i_en;
  logic             i_load;
  logic [CNT_W-1:0] i_preset;
  logic             i_monitor_in;
  logic             o_state;
  logic             o_active;
  logic             o_inactive;

  modport master (
    output i_en, i_load, i_preset, i_monitor_in,
    input  o_state, o_active, o_inactive
  );

  modport slave (
    input  i_en, i_load, i_preset, i_monitor_in,
    output o_state, o_active, o_inactive
  );
endinterface

// File: rtl/uart_watch_dog.sv
// UART RX activity watchdog with programmable idle timeout; UART_WDG_SYNC_EN adds a 2-flop input synchronizer.
// Latency: line edge to state/active is 1 cycle (3 cycles with the synchronizer); all outputs registered.
// Backpressure: none, free-running monitor with no flow control.
module uart_watch_dog #(
  parameter int CNT_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  uart_watch_dog_if.slave bus
);

`ifdef UART_WDG_SYNC_EN
  // Priming also covers the two cycles needed to flush reset zeros out of the synchronizer.
  localparam logic [1:0] PRIME_CYC = 2'd3;
  logic r_sync1;
  logic r_sync2;
  logic w_mon;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.i_monitor_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_mon = r_sync2;
`else
  localparam logic [1:0] PRIME_CYC = 2'd1;
  logic w_mon;

  assign w_mon = bus.i_monitor_in;
`endif

  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mon_d;
  logic [1:0]       r_prime_cnt;
  logic             r_state;
  logic             r_active;
  logic             r_inactive;
  logic             w_primed;
  logic             w_act;

  assign w_primed = (r_prime_cnt == PRIME_CYC);
  assign w_act    = w_primed & (w_mon ^ r_mon_d);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_preset    <= '0;
      r_cnt       <= '0;
      r_mon_d     <= 1'b0;
      r_prime_cnt <= 2'd0;
      r_state     <= 1'b0;
      r_active    <= 1'b0;
      r_inactive  <= 1'b0;
    end else begin
      r_mon_d <= w_mon;
      if (!w_primed) begin
        r_prime_cnt <= r_prime_cnt + 2'd1;
      end
      // New preset only lands in the register; the running count keeps its old reload.
      if (bus.i_load) begin
        r_preset <= bus.i_preset;
      end

      if (!bus.i_en) begin
        r_cnt      <= '0;
        r_state    <= 1'b0;
        r_active   <= 1'b0;
        r_inactive <= 1'b0;
      end else if (w_act) begin
        r_cnt      <= r_preset;
        r_state    <= 1'b1;
        r_active   <= ~r_state;
        r_inactive <= 1'b0;
      end else if (r_state) begin
        r_active <= 1'b0;
        if (r_cnt != '0) begin
          r_cnt      <= r_cnt - CNT_W'(1);
          r_inactive <= 1'b0;
        end else begin
          r_state    <= 1'b0;
          r_inactive <= 1'b1;
        end
      end else begin
        r_cnt      <= '0;
        r_active   <= 1'b0;
        r_inactive <= 1'b0;
      end
    end
  end

  assign bus.o_state    = r_state;
  assign bus.o_active   = r_active;
  assign bus.o_inactive = r_inactive;

endmodule

// File: tb/tb_uart_watch_dog.sv
// Randomized and directed bench for uart_watch_dog against a deadline-based reference model.
module tb_uart_watch_dog;

  localparam int CNT_W = 32;
`ifdef UART_WDG_SYNC_EN
  localparam int EXTRA_LAT = 2;
`else
  localparam int EXTRA_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_watch_dog_if #(.CNT_W(CNT_W)) wif ();

  uart_watch_dog #(.CNT_W(CNT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (wif.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int hi_cycles, act_cnt, inact_cnt;

  // Reference model: the line is active while the current cycle is within the
  // deadline set by the last qualifying edge (edge cycle + preset).
  longint     t;
  longint     deadline;
  logic [31:0] m_preset;
  int         m_prime;
  logic       m_prev;
  logic       m_s1, m_s2;
  logic       e_state, e_act, e_inact;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_tick();
    logic mon_now;
    logic act;
    logic old_state;
    if (rst) begin
      t = 0; deadline = -1; m_preset = '0; m_prime = 0; m_prev = 1'b0;
      m_s1 = 1'b0; m_s2 = 1'b0;
      e_state = 1'b0; e_act = 1'b0; e_inact = 1'b0;
      return;
    end
    t++;
`ifdef UART_WDG_SYNC_EN
    mon_now = m_s2;
    m_s2 = m_s1;
    m_s1 = wif.i_monitor_in;
`else
    mon_now = wif.i_monitor_in;
`endif
    act = (m_prime >= 1 + EXTRA_LAT) && (mon_now != m_prev);
    m_prev = mon_now;
    if (m_prime < 1 + EXTRA_LAT) m_prime++;
    old_state = e_state;
    if (!wif.i_en) begin
      e_state = 1'b0; e_act = 1'b0; e_inact = 1'b0; deadline = -1;
    end else if (act) begin
      deadline = t + longint'(m_preset);
      e_state = 1'b1; e_act = !old_state; e_inact = 1'b0;
    end else begin
      e_act = 1'b0;
      e_state = old_state && (t <= deadline);
      e_inact = old_state && !e_state;
    end
    if (wif.i_load) m_preset = wif.i_preset;
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    chk("state", wif.o_state, e_state);
    chk("active", wif.o_active, e_act);
    chk("inactive", wif.o_inactive, e_inact);
    chk("excl", wif.o_active & wif.o_inactive, 1'b0);
    hi_cycles += int'(wif.o_state);
    act_cnt   += int'(wif.o_active);
    inact_cnt += int'(wif.o_inactive);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    hi_cycles = 0; act_cnt = 0; inact_cnt = 0;
  endtask

  task automatic load_preset(input logic [31:0] p);
    wif.i_load = 1'b1; wif.i_preset = p;
    step();
    wif.i_load = 1'b0;
    steps(3);
  endtask

  initial begin
    int n;
    wif.i_en = 1'b0; wif.i_load = 1'b0; wif.i_preset = '0; wif.i_monitor_in = 1'b0;
    clr();
    rst = 1'b1;
    steps(2);
    chk("rst_state", wif.o_state, 1'b0);
    chk("rst_active", wif.o_active, 1'b0);
    chk("rst_inactive", wif.o_inactive, 1'b0);
    rst = 1'b0;

    // Disabled: toggling must never raise anything.
    clr();
    for (int i = 0; i < 20; i++) begin
      wif.i_monitor_in = ~wif.i_monitor_in;
      step();
    end
    steps(4);
    chk("dis_hi", hi_cycles, 0);
    chk("dis_act", act_cnt + inact_cnt, 0);

    // Long timeout: 0xFF gives 256 active cycles.
    wif.i_en = 1'b1; wif.i_load = 1'b1; wif.i_preset = 32'hFF;
    steps(60);
    wif.i_load = 1'b0;
    clr();
    wif.i_monitor_in = 1'b1;
    steps(300);
    chk("ff_hi", hi_cycles, 256);
    chk("ff_act", act_cnt, 1);
    chk("ff_inact", inact_cnt, 1);

    // Repeated activity keeps the line active with a single active pulse.
    load_preset(32'd10);
    clr();
    for (int i = 0; i < 10; i++) begin
      wif.i_monitor_in = ~wif.i_monitor_in;
      steps(5);
    end
    chk("rep_act", act_cnt, 1);
    chk("rep_noinact", inact_cnt, 0);
    wif.i_monitor_in = ~wif.i_monitor_in;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (wif.o_inactive && n == 0) n = i;
    end
    chk("rep_timeout", n, 12 + EXTRA_LAT);

    // Zero preset: one active cycle.
    load_preset(32'd0);
    clr();
    wif.i_monitor_in = ~wif.i_monitor_in;
    steps(10);
    chk("z_hi", hi_cycles, 1);
    chk("z_act", act_cnt, 1);
    chk("z_inact", inact_cnt, 1);

    // Dropping enable mid-count clears state silently.
    load_preset(32'd100);
    wif.i_monitor_in = ~wif.i_monitor_in;
    steps(30);
    clr();
    wif.i_en = 1'b0;
    step();
    chk("drop_state", wif.o_state, 1'b0);
    steps(10);
    wif.i_en = 1'b1;
    steps(20);
    chk("drop_hi", hi_cycles, 0);
    chk("drop_inact", inact_cnt, 0);

    // Loading a new preset mid-count only affects the next reload.
    clr();
    wif.i_monitor_in = ~wif.i_monitor_in;
    steps(20);
    wif.i_load = 1'b1; wif.i_preset = 32'd3;
    step();
    wif.i_load = 1'b0;
    steps(130);
    chk("ld_hi_old", hi_cycles, 101);
    chk("ld_inact_old", inact_cnt, 1);
    clr();
    wif.i_monitor_in = ~wif.i_monitor_in;
    steps(20);
    chk("ld_hi_new", hi_cycles, 4);

    // Randomized traffic including occasional resets.
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      wif.i_en = ($urandom_range(0, 19) != 0);
      wif.i_load = ($urandom_range(0, 9) == 0);
      wif.i_preset = 32'($urandom_range(0, 12));
      if ($urandom_range(0, 5) == 0) wif.i_monitor_in = ~wif.i_monitor_in;
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
